// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a valid/ready/last byte stream in preamble, SFD,
// zero padding and CRC-32 FCS, then enforces the inter-frame gap.
module gmii_tx_framer #(
    parameter int unsigned MIN_PAYLOAD = 60,
    parameter int unsigned IFG_BYTES   = 12
) (
    input  logic        clk_125,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [15:0] underrun_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_DROP
    } state_t;

    localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    state_t      state_q, state_d;
    logic [7:0]  step_q, step_d;
    logic [10:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [15:0] underrun_count_q, underrun_count_d;
    logic [10:0] len_inc;
    logic [31:0] fcs;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Outputs are computed from the current state and registered, so the wire
    // lags the state by one cycle (SFD is on the wire while the state is DATA).
    always_comb begin
        state_d          = state_q;
        step_d           = step_q;
        len_d            = len_q;
        crc_d            = crc_q;
        txd_d            = 8'h00;
        tx_en_d          = 1'b0;
        tx_er_d          = 1'b0;
        frame_count_d    = frame_count_q;
        underrun_count_d = underrun_count_q;
        len_inc          = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
        fcs              = ~crc_q;

        case (state_q)
            S_IDLE: begin
                step_d = 8'd0;
                if (in_valid) state_d = S_PRE;
            end
            S_PRE: begin
                txd_d   = 8'h55;
                tx_en_d = 1'b1;
                if (step_q == 8'd6) begin
                    step_d  = 8'd0;
                    state_d = S_SFD;
                end else begin
                    step_d = step_q + 8'd1;
                end
            end
            S_SFD: begin
                txd_d   = 8'hD5;
                tx_en_d = 1'b1;
                crc_d   = 32'hFFFFFFFF;
                len_d   = 11'd0;
                state_d = S_DATA;
            end
            S_DATA: begin
                tx_en_d = 1'b1;
                if (in_valid) begin
                    txd_d = in_data;
                    crc_d = crc_byte(crc_q, in_data);
                    len_d = len_inc;
                    if (in_last) begin
                        step_d  = 8'd0;
                        state_d = (len_inc < MIN_LEN) ? S_PAD : S_FCS;
                    end
                end else begin
                    tx_er_d          = 1'b1;
                    underrun_count_d = underrun_count_q + 16'd1;
                    state_d          = S_DROP;
                end
            end
            S_PAD: begin
                tx_en_d = 1'b1;
                crc_d   = crc_byte(crc_q, 8'h00);
                len_d   = len_inc;
                if (len_inc >= MIN_LEN) begin
                    step_d  = 8'd0;
                    state_d = S_FCS;
                end
            end
            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs[{step_q[1:0], 3'b000} +: 8];
                if (step_q == 8'd3) begin
                    frame_count_d = frame_count_q + 16'd1;
                    step_d        = 8'd0;
                    state_d       = S_IFG;
                end else begin
                    step_d = step_q + 8'd1;
                end
            end
            S_IFG: begin
                // Jump straight to PRE when data is waiting so the gap stays exact.
                if (step_q == IFG_LAST) begin
                    step_d  = 8'd0;
                    state_d = in_valid ? S_PRE : S_IDLE;
                end else begin
                    step_d = step_q + 8'd1;
                end
            end
            S_DROP: begin
                if (in_valid && in_last) begin
                    step_d  = 8'd0;
                    state_d = S_IFG;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_125) begin
        if (reset) begin
            state_q          <= S_IDLE;
            step_q           <= 8'd0;
            len_q            <= 11'd0;
            crc_q            <= 32'hFFFFFFFF;
            txd_q            <= 8'h00;
            tx_en_q          <= 1'b0;
            tx_er_q          <= 1'b0;
            frame_count_q    <= 16'd0;
            underrun_count_q <= 16'd0;
        end else begin
            state_q          <= state_d;
            step_q           <= step_d;
            len_q            <= len_d;
            crc_q            <= crc_d;
            txd_q            <= txd_d;
            tx_en_q          <= tx_en_d;
            tx_er_q          <= tx_er_d;
            frame_count_q    <= frame_count_d;
            underrun_count_q <= underrun_count_d;
        end
    end

    assign in_ready       = (state_q == S_DATA) || (state_q == S_DROP);
    assign busy           = (state_q != S_IDLE);
    assign gmii_txd       = txd_q;
    assign gmii_tx_en     = tx_en_q;
    assign gmii_tx_er     = tx_er_q;
    assign frame_count    = frame_count_q;
    assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer: random and directed frames compared
// against a table-driven CRC frame model and wire-level timing counters.
module tb_gmii_tx_framer;

    localparam int MIN_PAYLOAD = 60;
    localparam int IFG_BYTES   = 12;

    typedef logic [7:0] bq_t[$];

    logic        clk_125 = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic [15:0] frame_count;
    logic [15:0] underrun_count;

    gmii_tx_framer #(.MIN_PAYLOAD(MIN_PAYLOAD), .IFG_BYTES(IFG_BYTES)) dut (
        .clk_125(clk_125), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .gmii_txd(gmii_txd),
        .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .busy(busy),
        .frame_count(frame_count), .underrun_count(underrun_count)
    );

    always #4 clk_125 = ~clk_125;

    int checks = 0;
    int errors = 0;
    logic [7:0]  payload[$];
    logic        lastf[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  wire_q[$];
    logic [31:0] crc_tbl[256];
    int cur_burst = 0, last_burst = 0, low_run = 0, last_gap = 0;
    int er_count = 0, ready_cycles = 0;
    int exp_frames = 0, exp_underruns = 0;
    logic       prev_en = 1'b0;
    logic [7:0] er_txd = 8'hFF;
    logic       er_en = 1'b0;

    // Wire monitor: collects transmitted bytes, burst and gap lengths.
    always @(negedge clk_125) begin
        if (gmii_tx_en) begin
            if (!prev_en) begin
                last_gap  = low_run;
                cur_burst = 0;
            end
            cur_burst++;
            wire_q.push_back(gmii_txd);
        end else begin
            if (prev_en) begin
                last_burst = cur_burst;
                low_run    = 0;
            end
            low_run++;
        end
        if (gmii_tx_er) begin
            er_count++;
            er_txd = gmii_txd;
            er_en  = gmii_tx_en;
        end
        if (in_ready) ready_cycles++;
        prev_en = gmii_tx_en;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] modelCrc(input bq_t d);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[k]) c = crc_tbl[c[7:0] ^ d[k]] ^ (c >> 8);
        return ~c;
    endfunction

    function automatic bq_t randomBytes(input int len);
        bq_t r;
        for (int k = 0; k < len; k++) r.push_back(8'($urandom_range(0, 255)));
        return r;
    endfunction

    task automatic queuePayload(input bq_t p);
        foreach (p[k]) begin
            payload.push_back(p[k]);
            lastf.push_back(k == p.size() - 1);
        end
    endtask

    // Expected wire bytes of a good frame: preamble, SFD, padded body, FCS.
    task automatic modelFrame(input bq_t p);
        bq_t body;
        logic [31:0] fcs;
        body = p;
        while (body.size() < MIN_PAYLOAD) body.push_back(8'h00);
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body[k]) exp_q.push_back(body[k]);
        fcs = modelCrc(body);
        for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
        exp_frames++;
    endtask

    task automatic clearAll();
        payload.delete();
        lastf.delete();
        exp_q.delete();
        wire_q.delete();
        ready_cycles = 0;
        repeat ($urandom_range(0, 4)) @(negedge clk_125);
    endtask

    // Presents the queued bytes; optional one-cycle valid gap or reset pulse.
    task automatic applyStimulus(input int gap_after, input int reset_at);
        int  i = 0;
        int  budget = 0;
        bit  gapped = 0;
        bit  did_reset = 0;
        logic rdy;
        while (i < payload.size() && budget < 5000) begin
            budget++;
            @(negedge clk_125);
            if (gap_after >= 0 && i == gap_after && !gapped) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                gapped   = 1;
                @(posedge clk_125);
                continue;
            end
            in_valid = 1'b1;
            in_data  = payload[i];
            in_last  = lastf[i];
            rdy      = in_ready;
            if (reset_at >= 0 && i == reset_at) begin
                reset = 1'b1;
                did_reset = 1;
                @(posedge clk_125);
                break;
            end
            @(posedge clk_125);
            if (rdy) i++;
        end
        @(negedge clk_125);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!did_reset) checkOutput("stim_done", 32'(i), 32'(payload.size()));
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk_125);
        while (busy && n < 3000) begin
            @(negedge clk_125);
            n++;
        end
        checkOutput("idle_reached", 32'(busy), 32'd0);
        @(negedge clk_125);
        #1;
    endtask

    task automatic compareWire(input string tag);
        int mism = 0;
        checkOutput({tag, "_len"}, 32'(wire_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < wire_q.size() && k < exp_q.size(); k++)
            if (wire_q[k] !== exp_q[k]) mism++;
        checkOutput({tag, "_bytes"}, 32'(mism), 32'd0);
    endtask

    task automatic goodFrame(input string tag, input bq_t p);
        int wire_len;
        clearAll();
        queuePayload(p);
        modelFrame(p);
        applyStimulus(-1, -1);
        waitIdle();
        wire_len = 8 + ((p.size() > MIN_PAYLOAD) ? p.size() : MIN_PAYLOAD) + 4;
        compareWire(tag);
        checkOutput({tag, "_burst"}, 32'(last_burst), 32'(wire_len));
        checkOutput({tag, "_frames"}, 32'(frame_count), 32'(exp_frames));
        checkOutput({tag, "_ready"}, 32'(ready_cycles), 32'(p.size()));
    endtask

    initial begin
        bq_t p, p2, ascii;
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[n] = c;
        end
        for (int k = 0; k < 9; k++) ascii.push_back(8'h31 + 8'(k));
        checkOutput("model_crc_check", modelCrc(ascii), 32'hCBF43926);

        repeat (3) @(posedge clk_125);
        @(negedge clk_125);
        checkOutput("rst_txd", 32'(gmii_txd), 32'h00);
        checkOutput("rst_en", 32'(gmii_tx_en), 32'd0);
        checkOutput("rst_er", 32'(gmii_tx_er), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frames", 32'(frame_count), 32'd0);
        checkOutput("rst_underruns", 32'(underrun_count), 32'd0);
        reset = 1'b0;

        goodFrame("ascii9", ascii);
        p.delete();
        p.push_back(8'hAB);
        goodFrame("one_byte", p);
        goodFrame("exact_min", randomBytes(MIN_PAYLOAD));
        for (int r = 0; r < 4; r++) goodFrame("random", randomBytes($urandom_range(1, 120)));
        checkOutput("no_tx_er", 32'(er_count), 32'd0);

        // Two 64-byte frames with valid held high across the gap.
        clearAll();
        p  = randomBytes(64);
        p2 = randomBytes(64);
        queuePayload(p);
        queuePayload(p2);
        modelFrame(p);
        modelFrame(p2);
        applyStimulus(-1, -1);
        waitIdle();
        compareWire("b2b");
        checkOutput("b2b_gap", 32'(last_gap), 32'(IFG_BYTES));
        checkOutput("b2b_ready", 32'(ready_cycles), 32'd128);
        checkOutput("b2b_frames", 32'(frame_count), 32'(exp_frames));

        // Underrun after 10 of 100 bytes; remainder is drained.
        clearAll();
        p = randomBytes(100);
        queuePayload(p);
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < 10; k++) exp_q.push_back(p[k]);
        exp_q.push_back(8'h00);
        exp_underruns++;
        applyStimulus(10, -1);
        waitIdle();
        compareWire("underrun");
        checkOutput("underrun_burst", 32'(last_burst), 32'd19);
        checkOutput("underrun_er_count", 32'(er_count), 32'd1);
        checkOutput("underrun_er_txd", 32'(er_txd), 32'h00);
        checkOutput("underrun_er_en", 32'(er_en), 32'd1);
        checkOutput("underrun_count", 32'(underrun_count), 32'(exp_underruns));
        checkOutput("underrun_frames", 32'(frame_count), 32'(exp_frames));
        checkOutput("underrun_drain", 32'(ready_cycles), 32'd101);

        // Reset pulse while payload byte 30 is presented.
        clearAll();
        queuePayload(randomBytes(100));
        applyStimulus(-1, 29);
        checkOutput("midrst_en", 32'(gmii_tx_en), 32'd0);
        checkOutput("midrst_er", 32'(gmii_tx_er), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst_frames", 32'(frame_count), 32'd0);
        checkOutput("midrst_underruns", 32'(underrun_count), 32'd0);
        reset = 1'b0;
        exp_frames = 0;
        exp_underruns = 0;
        @(negedge clk_125);
        #1;
        checkOutput("midrst_burst", 32'(last_burst), 32'd37);
        checkOutput("midrst_no_er", 32'(er_count), 32'd1);
        goodFrame("after_rst", randomBytes(70));
        checkOutput("after_rst_underruns", 32'(underrun_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
